// File: rtl/screen_reader_if.sv
// VRAM pixel read port shared by the screen reader (master) and the video RAM (slave).
interface screen_reader_if;
  logic        p_read;
  logic [12:0] p_addr;
  logic [15:0] p_dout;

  modport master (output p_read, output p_addr, input p_dout);
  modport slave  (input p_read, input p_addr, output p_dout);
endinterface

// File: rtl/screen_reader.sv
// VGA 640x480 timing generator that fetches the 512x256 Hack screen from VRAM
// one word at a time and serialises it into a centred 1-bit pixel stream.
module screen_reader #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int X_OFFSET     = 64,
  parameter int Y_OFFSET     = 112,
  parameter int READ_LATENCY = 3
) (
  input  logic            clk,
  input  logic            reset,
  screen_reader_if.master vram,
  output logic            hsync,
  output logic            vsync,
  output logic            active,
  output logic            pixel
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int SCREEN_W = 512;
  localparam int SCREEN_H = 256;

  // p_read is registered, so the fetch slot is decoded one cycle before the
  // pulse, which itself leads the holding-register load by READ_LATENCY + 1.
  localparam logic [9:0] FETCH_DECODE = 10'(X_OFFSET - READ_LATENCY - 2);

  logic [9:0]              hcount;
  logic [9:0]              vcount;
  logic [9:0]              row_off;
  logic [9:0]              col_off;
  logic [9:0]              fetch_off;
  logic                    row_in;
  logic                    col_in;
  logic                    fetch_next;
  logic                    read_q;
  logic [12:0]             addr_q;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [15:0]             hold_q;
  logic [15:0]             shift_q;

  assign vram.p_read = read_q;
  assign vram.p_addr = addr_q;

  always_comb begin
    row_off    = vcount - 10'(Y_OFFSET);
    col_off    = hcount - 10'(X_OFFSET);
    fetch_off  = hcount - FETCH_DECODE;
    row_in     = (vcount >= 10'(Y_OFFSET)) && (row_off < 10'(SCREEN_H)) &&
                 (vcount < 10'(V_VISIBLE));
    col_in     = (hcount >= 10'(X_OFFSET)) && (col_off < 10'(SCREEN_W)) &&
                 (hcount < 10'(H_VISIBLE));
    fetch_next = row_in && (hcount >= FETCH_DECODE) &&
                 (fetch_off < 10'(SCREEN_W)) && (fetch_off[3:0] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == 10'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      active <= 1'b0;
    end else begin
      hsync  <= !((hcount >= 10'(HS_START)) && (hcount < 10'(HS_END)));
      vsync  <= !((vcount >= 10'(VS_START)) && (vcount < 10'(VS_END)));
      active <= (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_q <= 1'b0;
      addr_q <= '0;
    end else begin
      read_q <= fetch_next;
      if (fetch_next) begin
        addr_q <= {row_off[7:0], fetch_off[8:4]};
      end
    end
  end

  // Clearing the delay line drops any fetch in flight so no stale word survives reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
      hold_q  <= '0;
      shift_q <= '0;
      pixel   <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[READ_LATENCY-2:0], read_q};
      if (rd_pipe[READ_LATENCY-1]) begin
        hold_q <= vram.p_dout;
      end
      if (row_in && col_in) begin
        if (col_off[3:0] == 4'd0) begin
          pixel   <= hold_q[0];
          shift_q <= {1'b0, hold_q[15:1]};
        end else begin
          pixel   <= shift_q[0];
          shift_q <= {1'b0, shift_q[15:1]};
        end
      end else begin
        pixel <= 1'b0;
      end
    end
  end

endmodule
